// File: rtl/t05_wb_sram_responder.sv
// t05_wb_sram_responder: Wishbone classic subordinate backed by a word-addressed
// SRAM window. It has a programmable ack latency, returns a fixed pattern for
// addresses outside the window, and keeps saturating counts of in-window transfers.
module t05_wb_sram_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h3300_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          ACK_WAIT    = 0,
    parameter logic [31:0] OOR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        hwclk,
    input  logic        reset,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        oor_o,
    output logic [15:0] wr_count_o,
    output logic [15:0] rd_count_o
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] WIN_END   = ADDR_BASE + 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LAST = (ACK_WAIT > 0) ? 4'(ACK_WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;

    // Request fields captured in IDLE and used unchanged through ACK.
    logic            we_q;
    logic [3:0]      sel_q;
    logic [31:0]     wdat_q;
    logic [AW-1:0]   idx_q;
    logic            in_win_q;

    // Registered bus outputs.
    logic            ack_q;
    logic [31:0]     rdat_q;
    logic            oor_q;
    logic [15:0]     wr_cnt_q;
    logic [15:0]     rd_cnt_q;

    logic [31:0]     mem [DEPTH_WORDS];

    // Combinational helpers.
    logic            req;
    logic [31:0]     adr_word;
    logic [31:0]     offset;
    logic            in_win_d;
    logic [AW-1:0]   idx_d;
    logic            enter_ack;
    logic            xfer_we;
    logic            xfer_in_win;
    logic [AW-1:0]   xfer_idx;
    logic [31:0]     rdat_d;

    // Decode the bus address and pick the request fields that feed the ACK cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        req         = wbs_cyc_i & wbs_stb_i;
        adr_word    = wbs_adr_i & 32'hFFFF_FFFC;
        offset      = adr_word - ADDR_BASE;
        in_win_d    = (adr_word >= ADDR_BASE) && (adr_word < WIN_END);
        idx_d       = AW'(offset >> 2);
        enter_ack   = 1'b0;
        xfer_we     = we_q;
        xfer_in_win = in_win_q;
        xfer_idx    = idx_q;
        rdat_d      = 32'h0;

        // With zero wait the ACK cycle is entered straight from IDLE, so the
        // live bus fields are used instead of the not-yet-captured copies.
        if (state_q == ST_IDLE) begin
            xfer_we     = wbs_we_i;
            xfer_in_win = in_win_d;
            xfer_idx    = idx_d;
            enter_ack   = req && (ACK_WAIT == 0);
        end else if (state_q == ST_WAIT) begin
            enter_ack   = req && (cnt_q == WAIT_LAST);
        end

        if (!xfer_we) begin
            rdat_d = xfer_in_win ? mem[xfer_idx] : OOR_DATA;
        end
    end

    // Transfer FSM with registered ack/data/oor outputs and saturating counters.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            sel_q    <= 4'd0;
            wdat_q   <= 32'h0;
            idx_q    <= '0;
            in_win_q <= 1'b0;
            ack_q    <= 1'b0;
            rdat_q   <= 32'h0;
            oor_q    <= 1'b0;
            wr_cnt_q <= 16'h0;
            rd_cnt_q <= 16'h0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
            ack_q  <= 1'b0;
            rdat_q <= 32'h0;
            oor_q  <= 1'b0;

            if (enter_ack) begin
                ack_q  <= 1'b1;
                rdat_q <= rdat_d;
                oor_q  <= ~xfer_in_win;
            end

            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        we_q     <= wbs_we_i;
                        sel_q    <= wbs_sel_i;
                        wdat_q   <= wbs_dat_i;
                        idx_q    <= idx_d;
                        in_win_q <= in_win_d;
                        cnt_q    <= 4'd0;
                        state_q  <= (ACK_WAIT == 0) ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == WAIT_LAST) begin
                            state_q <= ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                    if (in_win_q) begin
                        if (we_q && (wr_cnt_q != 16'hFFFF)) begin
                            wr_cnt_q <= wr_cnt_q + 16'd1;
                        end
                        if (!we_q && (rd_cnt_q != 16'hFFFF)) begin
                            rd_cnt_q <= rd_cnt_q + 16'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Byte-lane write commit on the ACK edge; a reset on that edge abandons it.
    always_ff @(posedge hwclk) begin
        // NOTE: memory has no reset on purpose; contents survive reset like a real SRAM.
        if (!reset && (state_q == ST_ACK) && we_q && in_win_q) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
                end
            end
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = rdat_q;
    assign oor_o      = oor_q;
    assign wr_count_o = wr_cnt_q;
    assign rd_count_o = rd_cnt_q;

endmodule

// File: tb/tb_t05_wb_sram_responder.sv
// Directed bench for t05_wb_sram_responder: a zero-wait and a three-wait instance
// share one bus; dut_sel routes cyc to one of them and muxes its outputs back.
module tb_t05_wb_sram_responder;

    localparam logic [31:0] BASE  = 32'h3300_0000;
    localparam int          LIMIT = 40;

    logic        hwclk = 1'b0;
    logic        reset;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        dut_sel;

    logic        ack0, ack3, oor0, oor3;
    logic [31:0] dat0, dat3;
    logic [15:0] wr0, wr3, rd0, rd3;

    logic        ack, oor;
    logic [31:0] dat;
    logic [15:0] wrc, rdc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 hwclk = ~hwclk;

    assign ack = dut_sel ? ack3 : ack0;
    assign oor = dut_sel ? oor3 : oor0;
    assign dat = dut_sel ? dat3 : dat0;
    assign wrc = dut_sel ? wr3  : wr0;
    assign rdc = dut_sel ? rd3  : rd0;

    t05_wb_sram_responder #(.ACK_WAIT(0)) dut0 (
        .hwclk(hwclk), .reset(reset),
        .wbs_cyc_i(cyc & ~dut_sel), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack0), .wbs_dat_o(dat0), .oor_o(oor0),
        .wr_count_o(wr0), .rd_count_o(rd0)
    );

    t05_wb_sram_responder #(.ACK_WAIT(3)) dut3 (
        .hwclk(hwclk), .reset(reset),
        .wbs_cyc_i(cyc & dut_sel), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack3), .wbs_dat_o(dat3), .oor_o(oor3),
        .wr_count_o(wr3), .rd_count_o(rd3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transfer, called on a negedge; returns on the negedge where ack was seen.
    task automatic xfer(input string tag, input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input logic exp_oor,
                        input logic chk_dat, input logic [31:0] exp_dat);
        int lat;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
        lat = 0;
        do begin
            @(negedge hwclk);
            lat++;
        end while (!ack && lat < LIMIT);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_oor"}, {31'h0, oor}, {31'h0, exp_oor});
        if (chk_dat) check({tag, "_dat"}, dat, exp_dat);
        cyc = 1'b0; stb = 1'b0;
        @(negedge hwclk);
        check({tag, "_ack_low"}, {31'h0, ack}, 32'h0);
    endtask

    initial begin
        int n;
        int extra;
        reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = 32'h0; wdat = 32'h0; dut_sel = 1'b0;
        repeat (3) @(negedge hwclk);
        reset = 1'b0;

        // Reset state of both instances.
        check("rst_ack0", {31'h0, ack0}, 32'h0);
        check("rst_dat0", dat0, 32'h0);
        check("rst_oor0", {31'h0, oor0}, 32'h0);
        check("rst_cnt0", {wr0, rd0}, 32'h0);
        check("rst_ack3", {31'h0, ack3}, 32'h0);
        check("rst_cnt3", {wr3, rd3}, 32'h0);

        // Zero-wait write then read-back.
        xfer("t1_wr", 1'b1, 4'hF, BASE + 32'd8, 32'hA5A5_1234, 1, 1'b0, 1'b0, 32'h0);
        xfer("t1_rd", 1'b0, 4'hF, BASE + 32'd8, 32'h0, 1, 1'b0, 1'b1, 32'hA5A5_1234);
        check("t1_dat_idle", dat, 32'h0);
        check("t1_counts", {wrc, rdc}, {16'd1, 16'd1});

        // Byte lanes, sel=0 write, ignored low address bits.
        xfer("t2_wr_all", 1'b1, 4'hF, BASE + 32'd12, 32'hFFFF_FFFF, 1, 1'b0, 1'b0, 32'h0);
        xfer("t2_wr_5", 1'b1, 4'b0101, BASE + 32'd12, 32'h0000_0000, 1, 1'b0, 1'b0, 32'h0);
        xfer("t2_rd", 1'b0, 4'hF, BASE + 32'd12, 32'h0, 1, 1'b0, 1'b1, 32'hFF00_FF00);
        xfer("t2_wr_sel0", 1'b1, 4'b0000, BASE + 32'd12, 32'h1234_5678, 1, 1'b0, 1'b0, 32'h0);
        xfer("t2_rd_lowbits", 1'b0, 4'hF, BASE + 32'd14, 32'h0, 1, 1'b0, 1'b1, 32'hFF00_FF00);
        check("t2_counts", {wrc, rdc}, {16'd4, 16'd3});

        // Last word of the window is in range.
        xfer("t4_wr_last", 1'b1, 4'hF, BASE + 32'd1020, 32'h7E57_0FF0, 1, 1'b0, 1'b0, 32'h0);
        xfer("t4_rd_last", 1'b0, 4'hF, BASE + 32'd1020, 32'h0, 1, 1'b0, 1'b1, 32'h7E57_0FF0);

        // Out of window on both sides; counts and memory untouched.
        xfer("t4_rd_oor", 1'b0, 4'hF, BASE + 32'd1024, 32'h0, 1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        xfer("t4_wr_oor", 1'b1, 4'hF, BASE - 32'd4, 32'h0000_0000, 1, 1'b1, 1'b0, 32'h0);
        check("t4_counts", {wrc, rdc}, {16'd5, 16'd4});
        xfer("t4_rd_kept", 1'b0, 4'hF, BASE + 32'd1020, 32'h0, 1, 1'b0, 1'b1, 32'h7E57_0FF0);

        // Three-wait instance: seed word 0.
        dut_sel = 1'b1;
        xfer("t3_wr", 1'b1, 4'hF, BASE, 32'h1122_3344, 4, 1'b0, 1'b0, 32'h0);
        check("t3_wr_count", {16'h0, wrc}, 32'd1);

        // Held read: first ack after 4 cycles, one-cycle pulse, second 5 cycles later.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE;
        n = 0;
        do begin
            @(negedge hwclk);
            n++;
        end while (!ack && n < LIMIT);
        check("t3_first_lat", 32'(n), 32'd4);
        check("t3_first_dat", dat, 32'h1122_3344);
        @(negedge hwclk);
        check("t3_ack_width", {31'h0, ack}, 32'h0);
        n = 1;
        while (!ack && n < LIMIT) begin
            @(negedge hwclk);
            n++;
        end
        check("t3_second_gap", 32'(n), 32'd5);
        check("t3_second_dat", dat, 32'h1122_3344);
        cyc = 1'b0; stb = 1'b0;
        extra = 0;
        repeat (8) begin
            @(negedge hwclk);
            if (ack) extra++;
        end
        check("t3_no_third", 32'(extra), 32'd0);
        check("t3_rd_count", {16'h0, rdc}, 32'd2);

        // Abort: stb dropped after two cycles in WAIT.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE; wdat = 32'hCAFE_F00D;
        extra = 0;
        repeat (2) begin
            @(negedge hwclk);
            if (ack) extra++;
        end
        cyc = 1'b0; stb = 1'b0;
        repeat (8) begin
            @(negedge hwclk);
            if (ack) extra++;
        end
        check("t5_no_ack", 32'(extra), 32'd0);
        check("t5_wr_count", {16'h0, wrc}, 32'd1);
        xfer("t5_rd", 1'b0, 4'hF, BASE, 32'h0, 4, 1'b0, 1'b1, 32'h1122_3344);

        // Reset while a write sits in WAIT.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE; wdat = 32'h55AA_55AA;
        @(negedge hwclk);
        reset = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(negedge hwclk);
        reset = 1'b0;
        check("t6_ack", {31'h0, ack}, 32'h0);
        check("t6_counts", {wrc, rdc}, 32'h0);
        extra = 0;
        repeat (6) begin
            @(negedge hwclk);
            if (ack) extra++;
        end
        check("t6_no_ack", 32'(extra), 32'd0);
        xfer("t6_rd", 1'b0, 4'hF, BASE, 32'h0, 4, 1'b0, 1'b1, 32'h1122_3344);
        check("t6_rd_count", {wrc, rdc}, {16'd0, 16'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
